// File: rtl/qsfp_module_ctrl.sv
// qsfp_module_ctrl: sideband controller for CHANNELS QSFP/SFP cages.
// Handles pin sync/debounce, timed module reset/init sequencing, modsel and
// lpmode gating, and a latched event irq.
module qsfp_module_ctrl #(
    parameter int CHANNELS        = 2,
    parameter int DEBOUNCE_CYCLES = 1024,
    parameter int RESET_CYCLES    = 4096,
    parameter int INIT_CYCLES     = 65536,
    parameter int CNT_W           = 17
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [CHANNELS-1:0] modprsl,
    input  logic [CHANNELS-1:0] intl,
    output logic [CHANNELS-1:0] resetl,
    output logic [CHANNELS-1:0] modsell,
    output logic [CHANNELS-1:0] lpmode,
    input  logic [CHANNELS-1:0] lpmode_req,
    input  logic [CHANNELS-1:0] sw_reset,
    input  logic [CHANNELS-1:0] int_clear,
    output logic [CHANNELS-1:0] present,
    output logic [CHANNELS-1:0] ready,
    output logic [CHANNELS-1:0] event_pending,
    output logic                irq
);

    typedef enum logic [1:0] {
        ST_ABSENT,
        ST_RESET,
        ST_INIT,
        ST_READY
    } state_t;

    // Both pin kinds share one sync/debounce path: low half is "present"
    // (inverted modprsl), high half is intl. Idle levels: absent, no interrupt.
    localparam int               NP         = 2 * CHANNELS;
    localparam logic [NP-1:0]    PIN_IDLE   = {{CHANNELS{1'b1}}, {CHANNELS{1'b0}}};
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
    localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] INIT_LAST  = CNT_W'(INIT_CYCLES - 1);

    logic [NP-1:0]       pin_raw;
    logic [NP-1:0]       sync1;
    logic [NP-1:0]       sync2;
    logic [NP-1:0]       deb;
    logic [NP-1:0]       deb_prev;
    logic [CNT_W-1:0]    deb_cnt [NP];

    state_t              state      [CHANNELS];
    state_t              state_next [CHANNELS];
    logic [CNT_W-1:0]    seq_cnt      [CHANNELS];
    logic [CNT_W-1:0]    seq_cnt_next [CHANNELS];

    logic [CHANNELS-1:0] present_db;
    logic [CHANNELS-1:0] ev_set;
    logic [CHANNELS-1:0] ev_pending;

    assign pin_raw    = {intl, ~modprsl};
    assign present_db = deb[CHANNELS-1:0];

    // Two-flop synchroniser for the asynchronous cage pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            sync1 <= PIN_IDLE;
            sync2 <= PIN_IDLE;
        end else begin
            sync1 <= pin_raw;
            sync2 <= sync1;
        end
    end

    // Debouncer: accept a new level only after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clock) begin
        if (reset) begin
            deb      <= PIN_IDLE;
            deb_prev <= PIN_IDLE;
            for (int i = 0; i < NP; i++) begin
                deb_cnt[i] <= '0;
            end
        end else begin
            deb_prev <= deb;
            for (int i = 0; i < NP; i++) begin
                if (sync2[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DB_LAST) begin
                    deb[i]     <= sync2[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_cnt[i] + ONE;
                end
            end
        end
    end

    // Per-channel sequencing: removal beats sw_reset, which beats timer expiry.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_next[i]   = state[i];
            seq_cnt_next[i] = seq_cnt[i] + ONE;
            if (!present_db[i]) begin
                state_next[i]   = ST_ABSENT;
                seq_cnt_next[i] = '0;
            end else if (sw_reset[i] && (state[i] != ST_ABSENT)) begin
                state_next[i]   = ST_RESET;
                seq_cnt_next[i] = '0;
            end else begin
                case (state[i])
                    ST_ABSENT: begin
                        state_next[i]   = ST_RESET;
                        seq_cnt_next[i] = '0;
                    end
                    ST_RESET: begin
                        if (seq_cnt[i] == RST_LAST) begin
                            state_next[i]   = ST_INIT;
                            seq_cnt_next[i] = '0;
                        end
                    end
                    ST_INIT: begin
                        if (seq_cnt[i] == INIT_LAST) begin
                            state_next[i]   = ST_READY;
                            seq_cnt_next[i] = '0;
                        end
                    end
                    default: begin
                        seq_cnt_next[i] = '0;
                    end
                endcase
            end
        end
    end

    // Sequencer state and timer registers.
    always_ff @(posedge clock) begin
        for (int i = 0; i < CHANNELS; i++) begin
            if (reset) begin
                state[i]   <= ST_ABSENT;
                seq_cnt[i] <= '0;
            end else begin
                state[i]   <= state_next[i];
                seq_cnt[i] <= seq_cnt_next[i];
            end
        end
    end

    // Event sources: any debounced present edge, or an interrupt assertion seen in READY.
    always_comb begin
        ev_set = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            ev_set[i] = (deb[i] != deb_prev[i]) ||
                        (deb_prev[CHANNELS + i] && !deb[CHANNELS + i] &&
                         (state[i] == ST_READY));
        end
    end

    // Sticky event latch (set wins over clear) and the registered irq summary.
    always_ff @(posedge clock) begin
        if (reset) begin
            ev_pending <= '0;
            irq        <= 1'b0;
        end else begin
            ev_pending <= ev_set | (ev_pending & ~int_clear);
            irq        <= |ev_pending;
        end
    end

    // Cage pins decoded straight from the state register; lpmode follows software only in READY.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign ready[g]   = (state[g] == ST_READY);
        assign resetl[g]  = (state[g] == ST_INIT) || (state[g] == ST_READY);
        assign modsell[g] = (state[g] != ST_READY);
        assign lpmode[g]  = (state[g] == ST_READY) ? lpmode_req[g] : 1'b1;
    end

    assign present       = present_db;
    assign event_pending = ev_pending;

endmodule
